// File: rtl/alpha_trim_mean_if.sv
// alpha_trim_mean_if
//   Groups the sorter-facing inputs and the result outputs of the
//   alpha-trimmed mean stage.
//   Parameters must match the alpha_trim_mean instance it is attached to.
//   Signals:
//     sort_sig         window capture strobe (same pulse that starts the sorter)
//     data_unsort      DW*DN window samples, sample i at [i*DW +: DW]
//     sort_finish      sorter done pulse
//     sequence_sorted  rank-ordered sample indices, rank r at [r*DW_sequence +: DW_sequence]
//     mean_out         trimmed mean, held until the next result
//     mean_valid       one-cycle pulse when mean_out updates
//     busy             high whenever the stage is not idle
//     overrun          one-cycle pulse when a window is dropped
//   Modports: master drives the sorter side, slave is the mean stage.
interface alpha_trim_mean_if #(
    parameter int DN          = 25,
    parameter int DW          = 8,
    parameter int DW_sequence = $clog2(DN)
);
    logic                        sort_sig;
    logic [DW*DN-1:0]            data_unsort;
    logic                        sort_finish;
    logic [DW_sequence*DN-1:0]   sequence_sorted;
    logic [DW-1:0]               mean_out;
    logic                        mean_valid;
    logic                        busy;
    logic                        overrun;

    modport master (
        output sort_sig, data_unsort, sort_finish, sequence_sorted,
        input  mean_out, mean_valid, busy, overrun
    );

    modport slave (
        input  sort_sig, data_unsort, sort_finish, sequence_sorted,
        output mean_out, mean_valid, busy, overrun
    );
endinterface

// File: rtl/alpha_trim_mean.sv
// alpha_trim_mean
//   Alpha-trimmed mean stage placed after the parallel sorter. The window is
//   captured on sort_sig, the rank-ordered index list is taken one cycle after
//   sort_finish, the TRIM smallest and TRIM largest samples are dropped, the
//   remaining KEEP samples are accumulated one per cycle and the sum is divided
//   by KEEP with a sequential restoring divider (one quotient bit per cycle).
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  alpha_trim_mean_if.slave (sort_sig, data_unsort, sort_finish,
//          sequence_sorted in; mean_out, mean_valid, busy, overrun out)
//   Build option:
//     ATM_ROUND_EN  defined: round half up (dividend = sum + KEEP/2)
//                   undefined: truncate (dividend = sum)
//   Latency: mean_valid is high KEEP+SUM_W+2 cycles after an accepted
//   sort_finish (32 at the defaults) in both builds.
module alpha_trim_mean #(
    parameter int DN          = 25,
    parameter int DW          = 8,
    parameter int DW_sequence = $clog2(DN),
    parameter int TRIM        = 4
) (
    input  logic              clk,
    input  logic              rst,
    alpha_trim_mean_if.slave  bus
);

    localparam int KEEP  = DN - 2 * TRIM;
    localparam int SUM_W = DW + $clog2(DN);
    localparam int REM_W = $clog2(KEEP) + 1;
    localparam int CNT_W = $clog2(SUM_W);

    localparam logic [DW_sequence-1:0] RANK_FIRST = DW_sequence'(TRIM);
    localparam logic [DW_sequence-1:0] RANK_LAST  = DW_sequence'(DN - 1 - TRIM);
    localparam logic [CNT_W-1:0]       DIV_LAST   = CNT_W'(SUM_W - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SEQ = 3'd1,
        SEQ      = 3'd2,
        ACCUM    = 3'd3,
        DIVIDE   = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t state, state_nx;

    logic [DW*DN-1:0]          win_reg;
    logic [DW_sequence*DN-1:0] seq_reg;
    logic [SUM_W-1:0]          sum;
    logic [DW_sequence-1:0]    rank;
    logic [SUM_W-1:0]          dividend;
    logic [REM_W-1:0]          rem;
    // Only the low DW quotient bits are kept: sum <= KEEP*(2^DW-1) means the
    // upper quotient bits are always zero.
    logic [DW-1:0]             quotient;
    logic [CNT_W-1:0]          div_cnt;

    logic [DW-1:0]             mean_out_r;
    logic                      mean_valid_r;
    logic                      busy_r;
    logic                      overrun_r;

    logic [DW_sequence-1:0]    idx;
    logic [DW-1:0]             sample;
    logic [SUM_W-1:0]          acc_nx;
    logic [REM_W:0]            trial;
    logic                      q_bit;
    logic [REM_W-1:0]          rem_nx;
    logic [DW-1:0]             q_nx;

    // Dividend loaded into the divider once accumulation completes.
    function automatic logic [SUM_W-1:0] div_load(input logic [SUM_W-1:0] s);
`ifdef ATM_ROUND_EN
        return s + SUM_W'(KEEP >> 1);
`else
        return s;
`endif
    endfunction

    // Accumulate path: sample at the current rank.
    always_comb begin
        idx    = seq_reg[int'(rank) * DW_sequence +: DW_sequence];
        sample = win_reg[int'(idx) * DW +: DW];
        acc_nx = sum + SUM_W'(sample);
    end

    // Restoring divide step: shift in the next dividend bit, subtract the
    // divisor when it fits.
    always_comb begin
        trial  = {rem, dividend[SUM_W-1]};
        q_bit  = (trial >= (REM_W + 1)'(KEEP));
        rem_nx = q_bit ? REM_W'(trial - (REM_W + 1)'(KEEP)) : trial[REM_W-1:0];
        q_nx   = {quotient[DW-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.sort_finish) state_nx = SEQ;
            SEQ:     state_nx = ACCUM;
            ACCUM:   if (rank == RANK_LAST) state_nx = DIVIDE;
            DIVIDE:  if (div_cnt == DIV_LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_reg      <= '0;
            seq_reg      <= '0;
            sum          <= '0;
            rank         <= '0;
            dividend     <= '0;
            rem          <= '0;
            quotient     <= '0;
            div_cnt      <= '0;
            mean_out_r   <= '0;
            mean_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            // Window capture is only allowed while idle so an in-flight
            // accumulation never sees its samples change.
            if (state == IDLE && bus.sort_sig) begin
                win_reg <= bus.data_unsort;
            end

            // --- SEQ: sorter output arrives one cycle after sort_finish ---
            if (state == SEQ) begin
                seq_reg <= bus.sequence_sorted;
                sum     <= '0;
                rank    <= RANK_FIRST;
            end

            // --- ACCUM: one kept rank per cycle ---
            if (state == ACCUM) begin
                sum  <= acc_nx;
                rank <= rank + 1'b1;
                if (rank == RANK_LAST) begin
                    dividend <= div_load(acc_nx);
                    rem      <= '0;
                    quotient <= '0;
                    div_cnt  <= '0;
                end
            end

            // --- DIVIDE: one quotient bit per cycle, MSB first ---
            if (state == DIVIDE) begin
                dividend <= {dividend[SUM_W-2:0], 1'b0};
                rem      <= rem_nx;
                quotient <= q_nx;
                div_cnt  <= div_cnt + 1'b1;
                if (div_cnt == DIV_LAST) begin
                    mean_out_r <= q_nx;
                end
            end

            // Outputs are registered from the next state so they line up with
            // the state they describe.
            busy_r       <= (state_nx != IDLE);
            mean_valid_r <= (state_nx == DONE);
            overrun_r    <= bus.sort_finish && (state != IDLE);
        end
    end

    assign bus.mean_out   = mean_out_r;
    assign bus.mean_valid = mean_valid_r;
    assign bus.busy       = busy_r;
    assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_alpha_trim_mean.sv
// tb_alpha_trim_mean
//   Self-checking bench for alpha_trim_mean at the default parameters.
//   Acts as the upstream sorter: builds each window, derives the rank-ordered
//   index list, and compares mean_out, latency, busy width and overrun
//   against a sort-and-average reference model.
//   Define ATM_ROUND_EN for both bench and RTL to check the rounding build.
module tb_alpha_trim_mean;

    localparam int DN   = 25;
    localparam int DW   = 8;
    localparam int DWS  = $clog2(DN);
    localparam int TRIM = 4;
    localparam int KEEP = DN - 2 * TRIM;
    localparam int LAT  = KEEP + DW + $clog2(DN) + 2;

    logic clk;
    logic rst;

    alpha_trim_mean_if #(.DN(DN), .DW(DW), .DW_sequence(DWS)) bus ();

    alpha_trim_mean #(.DN(DN), .DW(DW), .DW_sequence(DWS), .TRIM(TRIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    logic [DW-1:0] win [DN];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: sort the values, drop TRIM at each end, average the rest.
    function automatic int ref_mean();
        int q[$];
        int s;
        s = 0;
        for (int i = 0; i < DN; i++) q.push_back(int'(win[i]));
        q.sort();
        for (int r = TRIM; r < DN - TRIM; r++) s += q[r];
`ifdef ATM_ROUND_EN
        return (s + KEEP / 2) / KEEP;
`else
        return s / KEEP;
`endif
    endfunction

    // Sorter stand-in: index list in ascending order of sample value.
    task automatic load_window(input bit invert);
        int idx [DN];
        int t;
        for (int i = 0; i < DN; i++) idx[i] = i;
        for (int i = 1; i < DN; i++) begin
            for (int j = i; j > 0 && win[idx[j-1]] > win[idx[j]]; j--) begin
                t = idx[j]; idx[j] = idx[j-1]; idx[j-1] = t;
            end
        end
        for (int i = 0; i < DN; i++) begin
            bus.data_unsort[i*DW +: DW] = invert ? ~win[i] : win[i];
            bus.sequence_sorted[i*DWS +: DWS] = DWS'(idx[i]);
        end
    endtask

    // Runs one window. Disturbances are given as cycle offsets k after F
    // (k=1 is the SEQ cycle); negative means none.
    task automatic run_window(input string tag, input bit same_cycle,
                              input int rst_at, input int fin_at, input int sig_at);
        int exp, got, vld_at, vcnt, busy_cnt, ovr_cnt, ovr_at;
        exp = ref_mean();
        got = -1; vld_at = -1; vcnt = 0; busy_cnt = 0; ovr_cnt = 0; ovr_at = -1;
        load_window(1'b0);
        bus.sort_sig    = 1'b1;
        bus.sort_finish = same_cycle;
        @(negedge clk);
        if (!same_cycle) begin
            bus.sort_sig    = 1'b0;
            bus.sort_finish = 1'b1;
            @(negedge clk);
        end
        for (int k = 1; k <= LAT + 8; k++) begin
            if (bus.busy) busy_cnt++;
            if (bus.overrun) begin ovr_cnt++; ovr_at = k; end
            if (bus.mean_valid) begin
                vcnt++;
                if (vld_at < 0) begin vld_at = k; got = int'(bus.mean_out); end
            end
            if (rst_at > 0 && k == rst_at + 1) begin
                chk({tag, " rst busy"}, int'(bus.busy), 0);
                chk({tag, " rst mean_out"}, int'(bus.mean_out), 0);
                chk({tag, " rst mean_valid"}, int'(bus.mean_valid), 0);
            end
            rst             = (k == rst_at);
            bus.sort_finish = (k == fin_at);
            bus.sort_sig    = (k == sig_at);
            load_window(k == sig_at);
            @(negedge clk);
        end
        if (rst_at > 0) begin
            chk({tag, " no valid after rst"}, vcnt, 0);
        end else begin
            chk({tag, " latency"}, vld_at, LAT);
            chk({tag, " valid pulses"}, vcnt, 1);
            chk({tag, " busy cycles"}, busy_cnt, LAT);
            chk({tag, " mean"}, got, exp);
            chk({tag, " mean held"}, int'(bus.mean_out), exp);
        end
        if (fin_at > 0) begin
            chk({tag, " overrun pulses"}, ovr_cnt, 1);
            chk({tag, " overrun cycle"}, ovr_at, fin_at + 1);
        end else begin
            chk({tag, " no overrun"}, ovr_cnt, 0);
        end
    endtask

    task automatic shuffle();
        int j;
        logic [DW-1:0] t;
        for (int i = DN - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = win[i]; win[i] = win[j]; win[j] = t;
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        bus.sort_sig = 1'b0;
        bus.sort_finish = 1'b0;
        bus.data_unsort = '0;
        bus.sequence_sorted = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset busy", int'(bus.busy), 0);
        chk("reset mean_out", int'(bus.mean_out), 0);
        chk("reset mean_valid", int'(bus.mean_valid), 0);
        chk("reset overrun", int'(bus.overrun), 0);
        @(negedge clk);

        for (int i = 0; i < DN; i++) win[i] = 8'd100;
        run_window("flat100", 1'b0, -1, -1, -1);

        for (int i = 0; i < DN; i++) win[i] = DW'(i);
        run_window("ramp", 1'b1, -1, -1, -1);
        chk("ramp const", int'(bus.mean_out), 12);

        for (int i = 0; i < DN; i++) win[i] = 8'd50;
        win[12] = 8'd255;
        run_window("impulse", 1'b0, -1, -1, -1);
        chk("impulse const", int'(bus.mean_out), 50);

        for (int i = 0; i < DN; i++)
            win[i] = (i < 4) ? 8'd0 : (i < 12) ? 8'd10 : (i < 21) ? 8'd11 : 8'd255;
        shuffle();
        run_window("round", 1'b0, -1, -1, -1);
`ifdef ATM_ROUND_EN
        chk("round const", int'(bus.mean_out), 11);
`else
        chk("round const", int'(bus.mean_out), 10);
`endif

        for (int i = 0; i < DN; i++) win[i] = 8'd255;
        run_window("full", 1'b1, -1, -1, -1);

        // Reset while accumulating: window abandoned, outputs cleared.
        for (int i = 0; i < DN; i++) win[i] = DW'($urandom_range(255, 1));
        run_window("rst_accum", 1'b0, 8, -1, -1);

        // Late sort_finish in DIVIDE and a stray sort_sig with different data
        // in ACCUM: the first result must be unaffected.
        for (int i = 0; i < DN; i++) win[i] = DW'($urandom_range(200, 20));
        run_window("overrun", 1'b0, -1, 25, 3);

        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < DN; i++) begin
                case (n % 3)
                    0: win[i] = DW'($urandom_range(255, 0));
                    1: win[i] = DW'($urandom_range(110, 100));
                    default: win[i] = ($urandom_range(9, 0) == 0) ?
                                      DW'($urandom_range(1, 0) * 255) :
                                      DW'($urandom_range(140, 120));
                endcase
            end
            run_window($sformatf("rand%0d", n), 1'(($urandom_range(1, 0))), -1, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alpha_trim_mean.md
# alpha_trim_mean

Alpha-trimmed mean stage that sits directly downstream of the parallel sorter in the modified alpha-mean filter datapath. It captures the 5×5 window at the moment the sort starts and takes the sorter's rank-ordered index list. It drops the TRIM smallest and TRIM largest samples, accumulates the remaining DN−2·TRIM samples one per cycle, and divides by that count with a sequential restoring divider. The result is one filtered pixel per window, delivered with a single-cycle valid pulse.

## Interface
- DN, 25: samples per window
- DW, 8: sample width
- DW_sequence, $clog2(DN): index width, matching the sorter
- TRIM, 4: samples discarded at each end; legal range 0 ≤ 2·TRIM < DN
- KEEP, DN−2·TRIM: samples averaged (derived, not overridable)
- SUM_W, DW+$clog2(DN): accumulator and dividend width
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- sort_sig  in  1  same pulse that starts the sorter; window capture strobe
- data_unsort  in  DW*DN  window samples, sample i at [i*DW+:DW]
- sort_finish  in  1  sorter done pulse
- sequence_sorted  in  DW_sequence*DN  sample index at each rank, ascending, rank r at [r*DW_sequence+:DW_sequence]
- mean_out  out  DW  trimmed mean, held until the next result
- mean_valid  out  1  one-cycle pulse when mean_out updates
- busy  out  1  high in any state other than IDLE
- overrun  out  1  one-cycle pulse when a window is dropped

## Operation
- FSM states: IDLE, WAIT_SEQ, SEQ, ACCUM, DIVIDE, DONE.
- IDLE:
  - On sort_sig, latch data_unsort into win_reg.
  - On sort_finish, go to SEQ.
  - sort_sig and sort_finish arriving in the same cycle is legal; both actions happen.
- SEQ:
  - Lasts one cycle. The sorter drives sequence_sorted one cycle after sort_finish.
  - Latch sequence_sorted into seq_reg.
  - Clear sum to 0 and set rank to TRIM.
  - Go to ACCUM.
- ACCUM:
  - Each cycle: sum += win_reg[seq_reg[rank]], then rank++.
  - After the add at rank DN−1−TRIM (exactly KEEP cycles), go to DIVIDE.
- DIVIDE:
  - Restoring division of the dividend by KEEP over SUM_W cycles, one quotient bit per cycle, MSB first.
  - Remainder register width is $clog2(KEEP)+1.
  - Dividend is sum, or sum+(KEEP>>1) when rounding is compiled in (see Configuration).
- DONE:
  - Lasts one cycle. mean_out ← quotient[DW-1:0]; mean_valid=1.
  - Go to IDLE.
  - The quotient always fits in DW bits because sum ≤ KEEP·(2^DW−1).
- Busy handling:
  - sort_sig is ignored in any state other than IDLE; win_reg is not overwritten.
  - sort_finish in any state other than IDLE drops that window: overrun pulses the next cycle and the FSM is unaffected.
- WAIT_SEQ is unreachable; it is reserved for a later registered sorter output. Any unreachable or illegal state goes to IDLE.
- TRIM=0 gives the plain arithmetic mean.
- Reset:
  - State IDLE; mean_out=0, mean_valid=0, busy=0, overrun=0; sum, rank, win_reg and seq_reg cleared.
  - Reset mid-operation abandons the window with no mean_valid.

## Timing
- Let F be the cycle with sort_finish=1 while in IDLE.
- SEQ occupies cycle F+1.
- ACCUM occupies F+2 … F+1+KEEP.
- DIVIDE occupies F+2+KEEP … F+1+KEEP+SUM_W.
- DONE is cycle F+2+KEEP+SUM_W, with mean_valid high.
- Defaults: mean_valid at F+32; busy high F+1…F+32.
- Minimum spacing between accepted windows is 33 cycles.
- busy is registered, so it rises in F+1.
- sort_sig for the next window is accepted from the cycle after DONE.

## Configuration
- ATM_ROUND_EN:
  - Defined: round half up. The dividend is sum+(KEEP>>1).
  - Undefined: truncate. The dividend is sum.
- SUM_W has enough headroom for the added KEEP>>1 at the defaults (4343 < 8192). Latency is identical in both builds.

## Test plan
- All 25 samples = 100 → mean_out=100; mean_valid exactly 32 cycles after sort_finish; busy high for 32 cycles.
- Samples 0…24 in order → kept ranks 4…20, sum 204 → mean_out=12 in both builds.
- 24 samples of 50 plus one sample of 255 at index 12 → mean_out=50; the impulse is removed.
- Rounding window: 4×0, 8×10, 9×11, 4×255 → kept sum 179 → mean_out=11 with ATM_ROUND_EN, 10 without.
- All samples 255 → mean_out=255 with no overflow.
- rst asserted in ACCUM → next cycle IDLE, outputs 0, no mean_valid. A second sort_finish during DIVIDE → one overrun pulse and the first result is unaffected.
